// File: rtl/spi_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_initiator
// Brief    : SPI mode-0 master issuing {rw_n, addr, data} frames to the bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_initiator #(
    parameter int SCLK_DIV      = 4,
    parameter int READY_TIMEOUT = 1024
) (
    input  logic        clk_sys_i,
    input  logic        reset_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_rw_ni,
    input  logic [16:0] cmd_addr_i,
    input  logic [7:0]  cmd_data_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_timeout_o,
    output logic        busy_o,
    output logic        spi_sclk_o,
    output logic        spi_cs_no,
    output logic        spi_tx_o,
    input  logic        spi_rx_i,
    input  logic        spi_ready_ni
);
    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GAP_W = $clog2(SCLK_DIV + 1);
    localparam int TMO_W = $clog2(READY_TIMEOUT + 1);
    localparam logic [DIV_W-1:0] c_div_last     = DIV_W'(SCLK_DIV - 1);
    localparam logic [GAP_W-1:0] c_gap          = GAP_W'(SCLK_DIV);
    localparam logic [TMO_W-1:0] c_tmo          = TMO_W'(READY_TIMEOUT);
    localparam logic [5:0]       c_last_cmd_bit = 6'd31;
    localparam logic [5:0]       c_last_rd_bit  = 6'd39;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETUP    = 3'd1,
        S_SHIFT    = 3'd2,
        S_WAIT_RDY = 3'd3,
        S_READ     = 3'd4,
        S_HOLD     = 3'd5
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_div, w_div_nxt;
    logic [5:0]       r_bit, w_bit_nxt;
    logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
    logic [GAP_W-1:0] r_gap, w_gap_nxt;
    logic [31:0]      r_sr, w_sr_nxt;
    logic [7:0]       r_rx, w_rx_nxt;
    logic             r_rw, w_rw_nxt;
    logic             r_to, w_to_nxt;
    logic             r_sclk, w_sclk_nxt;
    logic             r_cs_n, w_cs_n_nxt;
    logic             r_rsp_valid, w_rsp_valid_nxt;
    logic [7:0]       r_rsp_data, w_rsp_data_nxt;
    logic             r_rsp_to, w_rsp_to_nxt;
    logic [1:0]       r_rdy_sync;
    logic             w_rdy;
    logic             w_div_end;
    logic             w_accept;

    assign w_rdy     = ~r_rdy_sync[1];
    assign w_div_end = (r_div == c_div_last);
    assign w_accept  = cmd_valid_i && cmd_ready_o;

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_bit_nxt       = r_bit;
        w_tmo_nxt       = r_tmo;
        w_gap_nxt       = r_gap;
        w_sr_nxt        = r_sr;
        w_rx_nxt        = r_rx;
        w_rw_nxt        = r_rw;
        w_to_nxt        = r_to;
        w_sclk_nxt      = r_sclk;
        w_cs_n_nxt      = r_cs_n;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_to_nxt    = r_rsp_to;
        case (r_state)
            S_IDLE: begin
                if (r_gap != '0) w_gap_nxt = r_gap - 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_SETUP;
                    w_div_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_sr_nxt    = {cmd_rw_ni, 6'b0, cmd_addr_i, cmd_rw_ni ? 8'h00 : cmd_data_i};
                    w_rw_nxt    = cmd_rw_ni;
                    w_to_nxt    = 1'b0;
                    w_rx_nxt    = '0;
                    w_cs_n_nxt  = 1'b0;
                end
            end
            S_SETUP: begin
                if (w_div_end) begin
                    w_div_nxt   = '0;
                    w_sclk_nxt  = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            S_SHIFT: begin
                if (!w_div_end) begin
                    w_div_nxt = r_div + 1'b1;
                end else begin
                    w_div_nxt = '0;
                    if (r_sclk) begin
                        // Falling edge: present the next bit while SCLK is low.
                        w_sclk_nxt = 1'b0;
                        w_sr_nxt   = {r_sr[30:0], 1'b0};
                        w_bit_nxt  = r_bit + 1'b1;
                        if (r_bit == c_last_cmd_bit) begin
                            w_state_nxt = S_WAIT_RDY;
                            w_tmo_nxt   = '0;
                        end
                    end else begin
                        w_sclk_nxt = 1'b1;
                    end
                end
            end
            S_WAIT_RDY: begin
                // Ready is tested before the limit so a last-cycle ready still wins.
                if (w_rdy) begin
                    w_div_nxt   = '0;
                    w_state_nxt = r_rw ? S_READ : S_HOLD;
                end else if (r_tmo == c_tmo) begin
                    w_to_nxt    = 1'b1;
                    w_div_nxt   = '0;
                    w_state_nxt = S_HOLD;
                end else begin
                    w_tmo_nxt = r_tmo + 1'b1;
                end
            end
            S_READ: begin
                if (!w_div_end) begin
                    w_div_nxt = r_div + 1'b1;
                end else begin
                    w_div_nxt = '0;
                    if (r_sclk) begin
                        w_sclk_nxt = 1'b0;
                        w_bit_nxt  = r_bit + 1'b1;
                        if (r_bit == c_last_rd_bit) w_state_nxt = S_HOLD;
                    end else begin
                        w_sclk_nxt = 1'b1;
                        w_rx_nxt   = {r_rx[6:0], spi_rx_i};
                    end
                end
            end
            S_HOLD: begin
                if (w_div_end) begin
                    w_div_nxt       = '0;
                    w_cs_n_nxt      = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_data_nxt  = (r_rw && !r_to) ? r_rx : 8'h00;
                    w_rsp_to_nxt    = r_to;
                    w_gap_nxt       = c_gap;
                    w_state_nxt     = S_IDLE;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_bit       <= '0;
            r_tmo       <= '0;
            r_gap       <= c_gap;
            r_sr        <= '0;
            r_rx        <= '0;
            r_rw        <= 1'b0;
            r_to        <= 1'b0;
            r_sclk      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_to    <= 1'b0;
            r_rdy_sync  <= 2'b11;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_bit       <= w_bit_nxt;
            r_tmo       <= w_tmo_nxt;
            r_gap       <= w_gap_nxt;
            r_sr        <= w_sr_nxt;
            r_rx        <= w_rx_nxt;
            r_rw        <= w_rw_nxt;
            r_to        <= w_to_nxt;
            r_sclk      <= w_sclk_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_to    <= w_rsp_to_nxt;
            r_rdy_sync  <= {r_rdy_sync[0], spi_ready_ni};
        end
    end

    assign cmd_ready_o   = (r_state == S_IDLE) && (r_gap == '0);
    assign busy_o        = (r_state != S_IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_data_o    = r_rsp_data;
    assign rsp_timeout_o = r_rsp_to;
    assign spi_sclk_o    = r_sclk;
    assign spi_cs_no     = r_cs_n;
    assign spi_tx_o      = r_sr[31];

endmodule
`default_nettype wire
